// File: rtl/mouse_pkg.sv
// mouse_pkg: shared types, constants and helpers for the PS/2 mouse packet
// receiver.
//   rx_state_t  - byte-position FSM state (ST_B3 only with MOUSE_WHEEL_EN)
//   FLAG_*      - bit positions inside the packet flags byte
//   delta9_t    - 9-bit signed axis delta / accumulator value
//   delta10_t   - 10-bit signed intermediate for saturating sums
//   axis_delta  - builds a 9-bit delta from sign/overflow flags and a byte
//   sat_add     - 10-bit add of two 9-bit values, clamped to [lo, hi]
// Optional feature macro: MOUSE_WHEEL_EN (adds the fourth, wheel, byte).
package mouse_pkg;

`ifdef MOUSE_WHEEL_EN
  typedef enum logic [1:0] {ST_B0, ST_B1, ST_B2, ST_B3} rx_state_t;
`else
  typedef enum logic [1:0] {ST_B0, ST_B1, ST_B2} rx_state_t;
`endif

  localparam int unsigned FLAG_LEFT   = 0;
  localparam int unsigned FLAG_RIGHT  = 1;
  localparam int unsigned FLAG_MIDDLE = 2;
  localparam int unsigned FLAG_SYNC   = 3;
  localparam int unsigned FLAG_X_SIGN = 4;
  localparam int unsigned FLAG_Y_SIGN = 5;
  localparam int unsigned FLAG_X_OVF  = 6;
  localparam int unsigned FLAG_Y_OVF  = 7;

  typedef logic signed [8:0] delta9_t;
  typedef logic signed [9:0] delta10_t;

  localparam delta10_t XY_SAT_MIN = -10'sd256;
  localparam delta10_t XY_SAT_MAX = 10'sd255;
  localparam delta10_t Z_SAT_MIN  = -10'sd128;
  localparam delta10_t Z_SAT_MAX  = 10'sd127;

  // Latched flags byte; bit 3 (always-one sync bit) is not kept.
  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic middle;
    logic right;
    logic left;
  } pkt_flags_t;

  // Overflowed movement is reported as the extreme value in its direction.
  function automatic delta9_t axis_delta(logic ovf, logic sign, logic [7:0] mag);
    if (ovf) begin
      return sign ? delta9_t'(9'h100) : delta9_t'(9'h0FF);
    end
    return {sign, mag};
  endfunction

  function automatic delta9_t sat_add(delta9_t acc, delta9_t delta,
                                      delta10_t lo, delta10_t hi);
    delta10_t sum;
    sum = $signed({acc[8], acc}) + $signed({delta[8], delta});
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return sum[8:0];
  endfunction

endpackage

// File: rtl/mouse_axis_accum.sv
// mouse_axis_accum: one saturating movement accumulator for a single axis.
//   clk_sys - system clock (rising edge)
//   reset_n - asynchronous active-low reset, clears the accumulator
//   delta   - signed delta of the packet being committed
//   commit  - add delta this cycle
//   clear   - consumer acknowledge; zero the accumulator
//   acc     - saturated accumulator, low OUT_W bits (range bounded by SAT_*)
// With commit and clear together the new delta is added to zero, so the
// packet that arrives alongside the acknowledge is not lost.
module mouse_axis_accum
  import mouse_pkg::*;
#(
  parameter int unsigned OUT_W   = 9,
  parameter delta10_t    SAT_MIN = XY_SAT_MIN,
  parameter delta10_t    SAT_MAX = XY_SAT_MAX
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  delta9_t          delta,
  input  logic             commit,
  input  logic             clear,
  output logic [OUT_W-1:0] acc
);

  delta9_t acc_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (commit) begin
      acc_q <= sat_add(clear ? delta9_t'('0) : acc_q, delta, SAT_MIN, SAT_MAX);
    end else if (clear) begin
      acc_q <= '0;
    end
  end

  assign acc = acc_q[OUT_W-1:0];

endmodule

// File: rtl/mouse_packet_rx.sv
// mouse_packet_rx: assembles PS/2 mouse bytes into packets and accumulates
// saturated X/Y (and optionally Z) movement for a consumer.
//   clk_sys      - system clock (rising edge)
//   reset_n      - asynchronous active-low reset
//   rx_data      - byte from the PS/2 byte receiver
//   rx_valid     - one-cycle strobe qualifying rx_data
//   rd_ack       - one-cycle strobe: consumer sampled deltas, clear them
//   mouse_x/y    - signed 9-bit accumulated deltas (Y positive = up)
//   mouse_z      - signed 8-bit accumulated wheel delta (MOUSE_WHEEL_EN only)
//   mouse_left/middle/right - button state from the last committed packet
//   pkt_strobe   - one-cycle pulse per committed packet
//   sync_err     - one-cycle pulse on framing error or inter-byte timeout
// Optional feature macro: MOUSE_WHEEL_EN (4-byte packets with wheel byte).
module mouse_packet_rx
  import mouse_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rd_ack,
  output logic signed [8:0] mouse_x,
  output logic signed [8:0] mouse_y,
`ifdef MOUSE_WHEEL_EN
  output logic signed [7:0] mouse_z,
`endif
  output logic              mouse_left,
  output logic              mouse_middle,
  output logic              mouse_right,
  output logic              pkt_strobe,
  output logic              sync_err
);

  rx_state_t  state;
  logic [15:0] gap_cnt;
  pkt_flags_t flags_q;
  logic [7:0] x_q;
  logic       commit;
  delta9_t    dx;
  delta9_t    dy;
`ifdef MOUSE_WHEEL_EN
  logic [7:0] y_q;
  delta9_t    dz;

  assign commit = rx_valid && (state == ST_B3);
`else
  assign commit = rx_valid && (state == ST_B2);
`endif

  // The final byte is used straight off rx_data on the commit cycle.
  always_comb begin
    dx = axis_delta(flags_q.x_ovf, flags_q.x_sign, x_q);
`ifdef MOUSE_WHEEL_EN
    dy = axis_delta(flags_q.y_ovf, flags_q.y_sign, y_q);
    dz = {{5{rx_data[3]}}, rx_data[3:0]};
`else
    dy = axis_delta(flags_q.y_ovf, flags_q.y_sign, rx_data);
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_B0;
      gap_cnt      <= '0;
      flags_q      <= '0;
      x_q          <= '0;
`ifdef MOUSE_WHEEL_EN
      y_q          <= '0;
`endif
      mouse_left   <= 1'b0;
      mouse_middle <= 1'b0;
      mouse_right  <= 1'b0;
      pkt_strobe   <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      pkt_strobe <= 1'b0;
      sync_err   <= 1'b0;
      if (state == ST_B0) begin
        gap_cnt <= '0;
        if (rx_valid) begin
          if (rx_data[FLAG_SYNC]) begin
            flags_q <= '{
              y_ovf:  rx_data[FLAG_Y_OVF],
              x_ovf:  rx_data[FLAG_X_OVF],
              y_sign: rx_data[FLAG_Y_SIGN],
              x_sign: rx_data[FLAG_X_SIGN],
              middle: rx_data[FLAG_MIDDLE],
              right:  rx_data[FLAG_RIGHT],
              left:   rx_data[FLAG_LEFT]
            };
            state <= ST_B1;
          end else begin
            sync_err <= 1'b1;
          end
        end
      end else if (rx_valid) begin
        // A byte on the timeout cycle wins over the timeout.
        gap_cnt <= '0;
        case (state)
          ST_B1: begin
            x_q   <= rx_data;
            state <= ST_B2;
          end
`ifdef MOUSE_WHEEL_EN
          ST_B2: begin
            y_q   <= rx_data;
            state <= ST_B3;
          end
`endif
          default: begin
            // Final byte of the packet: commit (accumulators update in
            // mouse_axis_accum on this same edge).
            state        <= ST_B0;
            pkt_strobe   <= 1'b1;
            mouse_left   <= flags_q.left;
            mouse_middle <= flags_q.middle;
            mouse_right  <= flags_q.right;
          end
        endcase
      end else if (gap_cnt == TIMEOUT_CYCLES) begin
        state    <= ST_B0;
        gap_cnt  <= '0;
        sync_err <= 1'b1;
      end else begin
        gap_cnt <= gap_cnt + 16'd1;
      end
    end
  end

  mouse_axis_accum #(
    .OUT_W   (9),
    .SAT_MIN (XY_SAT_MIN),
    .SAT_MAX (XY_SAT_MAX)
  ) u_accum_x (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .delta   (dx),
    .commit  (commit),
    .clear   (rd_ack),
    .acc     (mouse_x)
  );

  mouse_axis_accum #(
    .OUT_W   (9),
    .SAT_MIN (XY_SAT_MIN),
    .SAT_MAX (XY_SAT_MAX)
  ) u_accum_y (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .delta   (dy),
    .commit  (commit),
    .clear   (rd_ack),
    .acc     (mouse_y)
  );

`ifdef MOUSE_WHEEL_EN
  mouse_axis_accum #(
    .OUT_W   (8),
    .SAT_MIN (Z_SAT_MIN),
    .SAT_MAX (Z_SAT_MAX)
  ) u_accum_z (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .delta   (dz),
    .commit  (commit),
    .clear   (rd_ack),
    .acc     (mouse_z)
  );
`endif

endmodule

// File: tb/tb_mouse_packet_rx.sv
// tb_mouse_packet_rx: directed bench for mouse_packet_rx (3-byte build).
// Expected packet results are queued as stimulus is driven and compared
// when the DUT pulses pkt_strobe.
module tb_mouse_packet_rx;

  localparam int T = 20;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rd_ack = 1'b0;
  logic signed [8:0] mouse_x;
  logic signed [8:0] mouse_y;
  logic              mouse_left;
  logic              mouse_middle;
  logic              mouse_right;
  logic              pkt_strobe;
  logic              sync_err;

  mouse_packet_rx #(.TIMEOUT_CYCLES(16'(T))) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rd_ack       (rd_ack),
    .mouse_x      (mouse_x),
    .mouse_y      (mouse_y),
    .mouse_left   (mouse_left),
    .mouse_middle (mouse_middle),
    .mouse_right  (mouse_right),
    .pkt_strobe   (pkt_strobe),
    .sync_err     (sync_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int x;
    int y;
    bit l;
    bit m;
    bit r;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mx = 0;
  int   my = 0;
  bit   ml = 0;
  bit   mm = 0;
  bit   mr = 0;
  int   strobe_cnt = 0;
  int   serr_cnt = 0;
  logic prev_strobe = 1'b0;
  logic prev_serr = 1'b0;

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat9(int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  function automatic int axis(bit ovf, bit sgn, logic [7:0] b);
    if (ovf) return sgn ? -256 : 255;
    return sgn ? int'(b) - 256 : int'(b);
  endfunction

  // Scoreboard consumer
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (pkt_strobe) begin
        exp_t e;
        strobe_cnt++;
        chk("strobe_width", prev_strobe, 0);
        chk("strobe_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("pkt_x", mouse_x, e.x);
          chk("pkt_y", mouse_y, e.y);
          chk("pkt_left", mouse_left, e.l);
          chk("pkt_middle", mouse_middle, e.m);
          chk("pkt_right", mouse_right, e.r);
        end
      end
      if (sync_err) begin
        serr_cnt++;
        chk("serr_width", prev_serr, 0);
      end
    end
    prev_strobe = pkt_strobe;
    prev_serr   = sync_err;
  end

  task automatic send_byte(logic [7:0] b, logic ack);
    @(negedge clk_sys);
    rx_data  = b;
    rx_valid = 1'b1;
    rd_ack   = ack;
    @(negedge clk_sys);
    rx_valid = 1'b0;
    rd_ack   = 1'b0;
  endtask

  task automatic expect_pkt(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic ack);
    exp_t e;
    mx = sat9((ack ? 0 : mx) + axis(b0[6], b0[4], b1));
    my = sat9((ack ? 0 : my) + axis(b0[7], b0[5], b2));
    ml = b0[0];
    mr = b0[1];
    mm = b0[2];
    e = '{mx, my, ml, mm, mr};
    q.push_back(e);
  endtask

  task automatic send_pkt(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic ack);
    expect_pkt(b0, b1, b2, ack);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, ack);
    @(negedge clk_sys);
    chk("pkt_drained", q.size(), 0);
  endtask

  task automatic do_ack();
    @(negedge clk_sys);
    rd_ack = 1'b1;
    @(negedge clk_sys);
    rd_ack = 1'b0;
    mx = 0;
    my = 0;
    chk("ack_x", mouse_x, 0);
    chk("ack_y", mouse_y, 0);
    chk("ack_left_kept", mouse_left, ml);
    chk("ack_right_kept", mouse_right, mr);
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_x"}, mouse_x, 0);
    chk({tag, "_y"}, mouse_y, 0);
    chk({tag, "_btn"}, {mouse_left, mouse_middle, mouse_right}, 0);
    chk({tag, "_strobe"}, pkt_strobe, 0);
    chk({tag, "_serr"}, sync_err, 0);
  endtask

  initial begin
    int n;
    int base_s;
    int base_e;

    // Reset state
    repeat (3) @(negedge clk_sys);
    chk_reset_state("reset");
    reset_n = 1'b1;

    // Basic packet: left button, +16/+32
    send_pkt(8'h09, 8'h10, 8'h20, 1'b0);
    chk("first_strobe_count", strobe_cnt, 1);
    do_ack();

    // Negative X, then X overflow positive
    send_pkt(8'h18, 8'hF0, 8'h00, 1'b0);
    send_pkt(8'h48, 8'h00, 8'h00, 1'b0);
    chk("x_after_ovf", mouse_x, 239);
    do_ack();

    // Positive saturation
    send_pkt(8'h08, 8'h7F, 8'h00, 1'b0);
    send_pkt(8'h08, 8'h7F, 8'h00, 1'b0);
    send_pkt(8'h08, 8'h7F, 8'h00, 1'b0);
    chk("x_sat_pos", mouse_x, 255);

    // Negative extremes and negative saturation
    send_pkt(8'hB8, 8'h00, 8'h00, 1'b0);
    send_pkt(8'hB8, 8'h00, 8'h00, 1'b0);
    chk("x_sat_neg", mouse_x, -256);
    chk("y_sat_neg", mouse_y, -256);
    do_ack();

    // Framing error in B0, then a normal packet
    base_e = serr_cnt;
    base_s = strobe_cnt;
    send_byte(8'h00, 1'b0);
    @(negedge clk_sys);
    chk("frame_serr", serr_cnt, base_e + 1);
    chk("frame_no_strobe", strobe_cnt, base_s);
    send_pkt(8'h2C, 8'h03, 8'h80, 1'b0);

    // Inter-byte timeout
    base_e = serr_cnt;
    send_byte(8'h08, 1'b0);
    n = 0;
    while (!sync_err && n < T + 10) begin
      @(negedge clk_sys);
      n++;
    end
    chk("timeout_gap", n, T + 1);
    @(negedge clk_sys);
    chk("timeout_serr", serr_cnt, base_e + 1);
    chk("timeout_acc_x", mouse_x, mx);
    send_pkt(8'h0A, 8'h02, 8'h03, 1'b0);

    // Byte landing exactly on the timeout cycle is accepted
    base_e = serr_cnt;
    expect_pkt(8'h09, 8'h04, 8'h02, 1'b0);
    send_byte(8'h09, 1'b0);
    repeat (T - 1) @(negedge clk_sys);
    send_byte(8'h04, 1'b0);
    send_byte(8'h02, 1'b0);
    @(negedge clk_sys);
    chk("edge_pkt_drained", q.size(), 0);
    chk("edge_no_serr", serr_cnt, base_e);
    do_ack();

    // rd_ack coinciding with commit
    send_pkt(8'h08, 8'h64, 8'h00, 1'b0);
    chk("x_before_ack", mouse_x, 100);
    send_pkt(8'h08, 8'h05, 8'h00, 1'b1);
    chk("x_ack_commit", mouse_x, 5);
    do_ack();

    // Reset in the middle of a packet
    send_byte(8'h09, 1'b0);
    send_byte(8'h10, 1'b0);
    @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    chk_reset_state("midreset");
    mx = 0;
    my = 0;
    ml = 0;
    mm = 0;
    mr = 0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    base_s = strobe_cnt;
    base_e = serr_cnt;
    send_byte(8'h20, 1'b0);
    repeat (3) @(negedge clk_sys);
    chk("midreset_no_strobe", strobe_cnt, base_s);
    chk("midreset_serr", serr_cnt, base_e + 1);
    send_pkt(8'h08, 8'h01, 8'h01, 1'b0);

    repeat (3) @(negedge clk_sys);
    chk("final_queue", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
